// File: rtl/spu_issue_scoreboard.sv
// Register-hazard scoreboard and dual-issue gate for the SPU even/odd pipes.
// Tracks cycles-to-writeback per register and gates issue on RAW/WAW hazards.
module spu_issue_scoreboard #(
    parameter int NUM_REGS = 128,
    parameter int REG_W    = 7,
    parameter int LAT_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_e,
    input  logic             we_e,
    input  logic [REG_W-1:0] rt_e,
    input  logic [LAT_W-1:0] lat_e,
    input  logic [REG_W-1:0] ra_e,
    input  logic [REG_W-1:0] rb_e,
    input  logic [REG_W-1:0] rc_e,
    input  logic [2:0]       use_e,
    input  logic             valid_o,
    input  logic             we_o,
    input  logic [REG_W-1:0] rt_o,
    input  logic [LAT_W-1:0] lat_o,
    input  logic [REG_W-1:0] ra_o,
    input  logic [REG_W-1:0] rb_o,
    input  logic [REG_W-1:0] rc_o,
    input  logic [2:0]       use_o,
    output logic             grant_e,
    output logic             grant_o,
    output logic [REG_W:0]   pending_cnt
);

    logic [LAT_W-1:0] cnt     [NUM_REGS];
    logic [LAT_W-1:0] cnt_nxt [NUM_REGS];
    logic [REG_W:0]   pop_nxt;

    logic src_blk_e, src_blk_o;
    logic waw_e, waw_o;
    logic raw_pair, waw_pair;
    logic ok_e, ok_o;
    logic clear;
    logic set_e, set_o;

    assign clear = reset || flush;

    assign src_blk_e = (use_e[0] && cnt[ra_e] != '0) ||
                       (use_e[1] && cnt[rb_e] != '0) ||
                       (use_e[2] && cnt[rc_e] != '0);
    assign src_blk_o = (use_o[0] && cnt[ra_o] != '0) ||
                       (use_o[1] && cnt[rb_o] != '0) ||
                       (use_o[2] && cnt[rc_o] != '0);

    // A new write may not complete before an older in-flight write to the same register.
    assign waw_e = we_e && (cnt[rt_e] > lat_e);
    assign waw_o = we_o && (cnt[rt_o] > lat_o);

    assign raw_pair = valid_e && we_e &&
                      ((use_o[0] && ra_o == rt_e) ||
                       (use_o[1] && rb_o == rt_e) ||
                       (use_o[2] && rc_o == rt_e));
    assign waw_pair = valid_e && we_e && we_o && (rt_o == rt_e);

    assign ok_e = valid_e && !src_blk_e && !waw_e;
    // Odd may only issue alongside or without an even instruction, never past a stalled one.
    assign ok_o = valid_o && (ok_e || !valid_e) && !src_blk_o && !waw_o &&
                  !raw_pair && !waw_pair;

    assign grant_e = ok_e && !clear;
    assign grant_o = ok_o && !clear;

    assign set_e = grant_e && we_e && (lat_e != '0);
    assign set_o = grant_o && we_o && (lat_o != '0);

    always_comb begin
        pop_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - 1'b1 : '0;
            if (set_e && rt_e == REG_W'(r))
                cnt_nxt[r] = lat_e;
            if (set_o && rt_o == REG_W'(r))
                cnt_nxt[r] = lat_o;
            pop_nxt = pop_nxt + {{REG_W{1'b0}}, (cnt_nxt[r] != '0)};
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
            pending_cnt <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= cnt_nxt[r];
            pending_cnt <= pop_nxt;
        end
    end

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// Directed bench for spu_issue_scoreboard: stimulus queues expected grants and
// pending count; a negedge monitor pops and compares against the DUT.
module tb_spu_issue_scoreboard;

    logic       clk = 1'b0;
    logic       reset, flush;
    logic       valid_e, we_e, valid_o, we_o;
    logic [6:0] rt_e, ra_e, rb_e, rc_e, rt_o, ra_o, rb_o, rc_o;
    logic [2:0] lat_e, lat_o, use_e, use_o;
    logic       grant_e, grant_o;
    logic [7:0] pending_cnt;

    logic [9:0] exp_q [$];
    logic       chk = 1'b0;
    int         n_total = 0;
    int         n_pass  = 0;
    int         vec     = 0;

    always #5 clk = ~clk;

    spu_issue_scoreboard dut (
        .clk(clk), .reset(reset), .flush(flush),
        .valid_e(valid_e), .we_e(we_e), .rt_e(rt_e), .lat_e(lat_e),
        .ra_e(ra_e), .rb_e(rb_e), .rc_e(rc_e), .use_e(use_e),
        .valid_o(valid_o), .we_o(we_o), .rt_o(rt_o), .lat_o(lat_o),
        .ra_o(ra_o), .rb_o(rb_o), .rc_o(rc_o), .use_o(use_o),
        .grant_e(grant_e), .grant_o(grant_o), .pending_cnt(pending_cnt)
    );

    always @(negedge clk) begin
        if (chk) begin
            logic [9:0] e;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL underflow vec %0d: no expected entry queued", vec);
            end else begin
                e = exp_q.pop_front();
                if ({grant_e, grant_o, pending_cnt} === e)
                    n_pass++;
                else
                    $display("FAIL vec %0d: got ge=%b go=%b pc=%0d, want ge=%b go=%b pc=%0d",
                             vec, grant_e, grant_o, pending_cnt, e[9], e[8], e[7:0]);
            end
        end
    end

    task automatic drive_e(input logic v, input logic w, input logic [6:0] rt,
                           input logic [2:0] lat, input logic [6:0] ra,
                           input logic [6:0] rb, input logic [6:0] rc,
                           input logic [2:0] u);
        valid_e = v; we_e = w; rt_e = rt; lat_e = lat;
        ra_e = ra; rb_e = rb; rc_e = rc; use_e = u;
    endtask

    task automatic drive_o(input logic v, input logic w, input logic [6:0] rt,
                           input logic [2:0] lat, input logic [6:0] ra,
                           input logic [6:0] rb, input logic [6:0] rc,
                           input logic [2:0] u);
        valid_o = v; we_o = w; rt_o = rt; lat_o = lat;
        ra_o = ra; rb_o = rb; rc_o = rc; use_o = u;
    endtask

    task automatic idle();
        drive_e(0, 0, 0, 0, 0, 0, 0, 0);
        drive_o(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Expectation describes the current cycle's inputs and pre-edge state.
    task automatic step(input logic ge, input logic go, input logic [7:0] pc);
        exp_q.push_back({ge, go, pc});
        chk = 1'b1;
        @(posedge clk);
        #1;
        chk = 1'b0;
        vec++;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        // Grants forced low during reset even with a valid instruction
        drive_e(1, 1, 5, 4, 0, 0, 0, 0);
        step(0, 0, 0);
        reset = 1'b0;

        // Write r5 with latency 4, then count down
        drive_e(1, 1, 5, 4, 0, 0, 0, 0); step(1, 0, 0);
        idle();                          step(0, 0, 1);   // cnt5=4
        idle();                          step(0, 0, 1);   // cnt5=3
        // Even reads r5 while pending: both pipes held (in-order)
        drive_e(1, 0, 0, 0, 5, 0, 0, 3'b001);
        drive_o(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1);                                    // cnt5=2
        step(0, 0, 1);                                    // cnt5=1
        step(1, 1, 0);                                    // cnt5=0

        // Intra-pair RAW on r10, then odd waits for the countdown
        drive_e(1, 1, 10, 3, 0, 0, 0, 0);
        drive_o(1, 0, 0, 0, 10, 0, 0, 3'b001);
        step(1, 0, 0);
        drive_e(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1);                                    // cnt10=3
        step(0, 0, 1);                                    // cnt10=2
        step(0, 0, 1);                                    // cnt10=1
        step(0, 1, 0);                                    // cnt10=0

        // Intra-pair WAW on r7
        drive_e(1, 1, 7, 2, 0, 0, 0, 0);
        drive_o(1, 1, 7, 1, 0, 0, 0, 0);
        step(1, 0, 0);
        idle();                          step(0, 0, 1);
        idle();                          step(0, 0, 1);

        // Scoreboard WAW on r9: cnt9=5, new write with lat 2 waits until cnt9<=2
        drive_e(1, 1, 9, 5, 0, 0, 0, 0); step(1, 0, 0);
        drive_e(1, 1, 9, 2, 0, 0, 0, 0);
        step(0, 0, 1);                                    // cnt9=5
        step(0, 0, 1);                                    // cnt9=4
        step(0, 0, 1);                                    // cnt9=3
        step(1, 0, 1);                                    // cnt9=2, reset to 2
        idle();                          step(0, 0, 1);   // cnt9=2
        idle();                          step(0, 0, 1);   // cnt9=1

        // lat==0 write creates no entry
        drive_e(1, 1, 3, 0, 0, 0, 0, 0); step(1, 0, 0);
        drive_e(1, 0, 0, 0, 3, 0, 0, 3'b001); step(1, 0, 0);

        // Three pending registers, then flush
        drive_e(1, 1, 20, 7, 0, 0, 0, 0);
        drive_o(1, 1, 21, 6, 0, 0, 0, 0);
        step(1, 1, 0);
        drive_e(1, 1, 22, 5, 0, 0, 0, 0);
        drive_o(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 2);
        flush = 1'b1;
        drive_e(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 3);
        flush = 1'b0;
        drive_e(1, 0, 0, 0, 20, 0, 0, 3'b001);
        drive_o(1, 0, 0, 0, 0, 22, 0, 3'b010);
        step(1, 1, 0);
        idle();

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL leftover: %0d expected entries not consumed, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
